rc_channel_scheduler: RTL and testbench

Sequencer that time-shares one RC charge-time measurement path among NUM_CH RC sensor channels. It selects enabled channels round-robin, drives each channel's step excitation, times charge-to-threshold, enforces a discharge interval, and hands each count to the shared resistance calculator / BCD pipeline with a start/done handshake. It sits between the per-channel RC pins and the calculator, replacing the single-channel charge/discharge control.

---
 rtl/rc_tdc_pkg.sv | 19 +
 rtl/rc_rr_arbiter.sv | 30 +++
 rtl/rc_channel_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_rc_channel_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc_tdc_pkg.sv
// Shared types and default parameters for the multi-channel RC charge-time
// scheduler and its round-robin channel picker.
package rc_tdc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_CHARGE,
      ST_DISCHARGE,
      ST_NEXT
   } sched_state_t;

   localparam int          DEF_NUM_CH    = 4;
   localparam int          DEF_CNT_W     = 24;
   localparam int unsigned DEF_TIMEOUT   = 32'h00FF_FFFF;
   localparam int unsigned DEF_MIN_DISCH = 1000;
   localparam int          DEF_AVG_LOG2  = 2;

endpackage

// File: rtl/rc_rr_arbiter.sv
// Combinational round-robin picker: returns the first enabled channel
// strictly after last_ch, wrapping around, plus a flag that any is enabled.
module rc_rr_arbiter
   import rc_tdc_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] mask,
   input  logic [CH_W-1:0]   last_ch,
   output logic [CH_W-1:0]   pick,
   output logic              any_valid
);

   // Walk from the farthest candidate back to the nearest so the nearest enabled channel wins
   always_comb begin
      logic [CH_W-1:0] cand;
      pick = '0;
      cand = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         cand = CH_W'((int'(last_ch) + k) % NUM_CH);
         if (mask[cand]) begin
            pick = cand;
         end
      end
   end

   assign any_valid = |mask;

endmodule

// File: rtl/rc_channel_scheduler.sv
// Time-shares one RC charge-time measurement path among NUM_CH sensor
// channels: round-robin selection, step excitation, charge timing with
// timeout, enforced discharge, and a start/done handshake to the shared
// resistance calculator.
// Optional build macro RC_SCHED_AVG_EN: each selection takes 2^AVG_LOG2
// back-to-back samples and reports their average.
module rc_channel_scheduler
   import rc_tdc_pkg::*;
#(
   parameter int          NUM_CH    = DEF_NUM_CH,
   parameter int          CNT_W     = DEF_CNT_W,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
   parameter int unsigned MIN_DISCH = DEF_MIN_DISCH,
   parameter int          AVG_LOG2  = DEF_AVG_LOG2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        run,
   input  logic [NUM_CH-1:0]           ch_enable,
   input  logic [NUM_CH-1:0]           step_input,
   output logic [NUM_CH-1:0]           step_set,
   output logic                        meas_valid,
   output logic [$clog2(NUM_CH)-1:0]   meas_ch,
   output logic [CNT_W-1:0]            meas_count,
   output logic                        meas_timeout,
   output logic                        calc_start,
   input  logic                        calc_done,
   output logic                        busy
);

   localparam int                CH_W   = $clog2(NUM_CH);
   localparam logic [CNT_W-1:0]  TO_VAL = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  TO_M1  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  MD     = CNT_W'(MIN_DISCH);
   localparam logic [NUM_CH-1:0] ONE    = NUM_CH'(1);

   // Configurations outside the supported range are rejected at elaboration
   if (NUM_CH < 2 || NUM_CH > 8 || AVG_LOG2 < 0) begin : g_bad_cfg
      $error("rc_channel_scheduler: unsupported NUM_CH or AVG_LOG2");
   end

   sched_state_t     state;
   logic [CH_W-1:0]  cur_ch;
   logic [CH_W-1:0]  last_ch;
   logic [CH_W-1:0]  pick;
   logic             any_valid;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] held_cnt;
   logic             start_issued;
   logic             done_seen;

   logic             hit;
   logic             timed_out;
   logic             latch_now;
   logic [CNT_W-1:0] sample_val;
   logic [CNT_W-1:0] report_cnt;
   logic [CNT_W-1:0] target;
   logic             done_ok;

`ifdef RC_SCHED_AVG_EN
   localparam int NSAMP = 1 << AVG_LOG2;

   logic [AVG_LOG2:0]         samp;
   logic [CNT_W+AVG_LOG2-1:0] accum;
   logic [CNT_W+AVG_LOG2-1:0] acc_sum;
   logic                      final_samp;
`endif

   rc_rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_arbiter (
      .mask      (ch_enable),
      .last_ch   (last_ch),
      .pick      (pick),
      .any_valid (any_valid)
   );

   // Charge-end detection, reported value and discharge exit condition
   always_comb begin
      hit        = step_input[cur_ch];
      timed_out  = !hit && (cnt == TO_M1);
      latch_now  = hit || timed_out;
      sample_val = hit ? cnt : TO_VAL;
      target     = (held_cnt > MD) ? held_cnt : MD;
      done_ok    = !start_issued || done_seen || calc_done;
`ifdef RC_SCHED_AVG_EN
      acc_sum    = accum + (CNT_W+AVG_LOG2)'(sample_val);
      report_cnt = timed_out ? TO_VAL : CNT_W'(acc_sum >> AVG_LOG2);
`else
      report_cnt = sample_val;
`endif
   end

   // Sequencer: selection, charge timing, discharge hold-off and handshake bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         cur_ch       <= '0;
         last_ch      <= CH_W'(NUM_CH - 1);
         cnt          <= '0;
         held_cnt     <= '0;
         start_issued <= 1'b0;
         done_seen    <= 1'b0;
         step_set     <= '0;
         meas_valid   <= 1'b0;
         meas_ch      <= '0;
         meas_count   <= '0;
         meas_timeout <= 1'b0;
         calc_start   <= 1'b0;
         busy         <= 1'b0;
`ifdef RC_SCHED_AVG_EN
         samp         <= '0;
         accum        <= '0;
         final_samp   <= 1'b0;
`endif
      end else begin
         meas_valid <= 1'b0;
         calc_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               step_set <= '0;
               if (run) begin
                  state <= ST_SELECT;
                  busy  <= 1'b1;
               end
            end

            ST_SELECT: begin
               start_issued <= 1'b0;
               done_seen    <= 1'b0;
               cnt          <= '0;
`ifdef RC_SCHED_AVG_EN
               samp         <= '0;
               accum        <= '0;
               final_samp   <= 1'b0;
`endif
               if (any_valid) begin
                  cur_ch   <= pick;
                  step_set <= ONE << pick;
                  state    <= ST_CHARGE;
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end

            ST_CHARGE: begin
               if (latch_now) begin
                  step_set <= '0;
                  cnt      <= '0;
                  held_cnt <= sample_val;
                  state    <= ST_DISCHARGE;
`ifdef RC_SCHED_AVG_EN
                  accum    <= acc_sum;
                  if (timed_out || int'(samp) == NSAMP - 1) begin
                     final_samp   <= 1'b1;
                     meas_valid   <= 1'b1;
                     meas_ch      <= cur_ch;
                     meas_count   <= report_cnt;
                     meas_timeout <= timed_out;
                     calc_start   <= !timed_out;
                     start_issued <= !timed_out;
                  end else begin
                     final_samp <= 1'b0;
                     samp       <= samp + 1'b1;
                  end
`else
                  meas_valid   <= 1'b1;
                  meas_ch      <= cur_ch;
                  meas_count   <= report_cnt;
                  meas_timeout <= timed_out;
                  calc_start   <= !timed_out;
                  start_issued <= !timed_out;
`endif
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_DISCHARGE: begin
               if (calc_done && start_issued) begin
                  done_seen <= 1'b1;
               end
               if (cnt != '1) begin
                  cnt <= cnt + CNT_W'(1);
               end
               if (cnt >= target && done_ok) begin
`ifdef RC_SCHED_AVG_EN
                  if (final_samp) begin
                     state <= ST_NEXT;
                  end else begin
                     cnt      <= '0;
                     step_set <= ONE << cur_ch;
                     state    <= ST_CHARGE;
                  end
`else
                  state <= ST_NEXT;
`endif
               end
            end

            ST_NEXT: begin
               last_ch <= cur_ch;
               if (run) begin
                  state <= ST_SELECT;
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state    <= ST_IDLE;
               step_set <= '0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rc_channel_scheduler.sv
// Self-checking bench for rc_channel_scheduler: a sensor model raises
// step_input a programmed number of charge cycles after excitation, a
// calculator model answers calc_start with calc_done, and a monitor pops
// expected measurements from a scoreboard queue on every meas_valid.
module tb_rc_channel_scheduler;

   typedef struct {
      int ch;
      int count;
      int to;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        run;
   logic [3:0]  ch_enable;
   logic [3:0]  step_input;
   logic [3:0]  step_set;
   logic        meas_valid;
   logic [1:0]  meas_ch;
   logic [23:0] meas_count;
   logic        meas_timeout;
   logic        calc_start;
   logic        calc_done;
   logic        busy;

   logic        resp_done;
   logic        stray_done;

   int          tests_run    = 0;
   int          tests_failed = 0;
   int          cycle        = 0;
   int          meas_seen    = 0;
   int          last_meas_cycle = 0;
   int          done_cycle   = 0;
   int          calc_delay   = 3;
   int          chg          = 0;
   int          cur_delay    = 0;
   int          delay_q[$];
   exp_t        exp_q[$];

   assign calc_done = resp_done | stray_done;

   rc_channel_scheduler #(
      .NUM_CH    (4),
      .CNT_W     (24),
      .TIMEOUT   (1000),
      .MIN_DISCH (1000),
      .AVG_LOG2  (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .ch_enable    (ch_enable),
      .step_input   (step_input),
      .step_set     (step_set),
      .meas_valid   (meas_valid),
      .meas_ch      (meas_ch),
      .meas_count   (meas_count),
      .meas_timeout (meas_timeout),
      .calc_start   (calc_start),
      .calc_done    (calc_done),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] mask, input logic run_val);
      ch_enable = mask;
      run       = run_val;
   endtask

   task automatic pushExpected(input int ch, input int count, input int to);
      exp_t e;
      e.ch    = ch;
      e.count = count;
      e.to    = to;
      exp_q.push_back(e);
   endtask

   task automatic waitIdle(input string name, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy !== 1'b0 && n < budget);
      checkOutput(name, int'(busy === 1'b0), 1);
   endtask

   task automatic waitStep(input string name, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (step_set === 4'b0000 && n < budget);
      checkOutput(name, int'(step_set !== 4'b0000), 1);
   endtask

   task automatic waitMeas(input string name, input int target, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (meas_seen < target && n < budget);
      checkOutput(name, int'(meas_seen >= target), 1);
   endtask

   // Sensor model: step_input rises cur_delay charge cycles after excitation (-1 = never)
   always @(negedge clk) begin
      if (reset || step_set == 4'b0000) begin
         step_input = 4'b0000;
         chg        = 0;
      end else begin
         if (chg == 0) begin
            cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 100;
         end
         if (cur_delay >= 0 && chg >= cur_delay) begin
            step_input = step_set;
         end
         chg++;
      end
   end

   // Calculator model: answers each calc_start with a one-cycle calc_done after calc_delay cycles
   initial resp_done = 1'b0;
   always @(negedge clk) begin
      if (calc_start) begin
         repeat (calc_delay) @(negedge clk);
         resp_done  = 1'b1;
         done_cycle = cycle;
         @(negedge clk);
         resp_done  = 1'b0;
      end
   end

   // Monitor: compare every presented measurement against the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (meas_valid) begin
         meas_seen++;
         last_meas_cycle = cycle;
         checkOutput("scoreboard_has_entry", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("meas_ch", int'(meas_ch), e.ch);
            checkOutput("meas_count", int'(meas_count), e.count);
            checkOutput("meas_timeout", int'(meas_timeout), e.to);
            checkOutput("calc_start_qual", int'(calc_start), int'(e.to == 0));
         end
      end else if (calc_start) begin
         checkOutput("calc_start_with_meas", int'(meas_valid), 1);
      end
      if ($countones(step_set) > 1) begin
         checkOutput("step_set_onehot", $countones(step_set), 1);
      end
   end

   // Watchdog so the run always terminates
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int gap;
      int idle_cycle;
      int base;

      reset      = 1'b1;
      stray_done = 1'b0;
      applyStimulus(4'b0000, 1'b0);
      repeat (3) @(negedge clk);

      checkOutput("rst_step_set", int'(step_set), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_meas_valid", int'(meas_valid), 0);
      checkOutput("rst_calc_start", int'(calc_start), 0);
      checkOutput("rst_meas_count", int'(meas_count), 0);
      checkOutput("rst_meas_ch", int'(meas_ch), 0);
      checkOutput("rst_meas_timeout", int'(meas_timeout), 0);

      reset = 1'b0;
      @(negedge clk);

      // Startup latency: SELECT one cycle after run, excitation the cycle after that
      delay_q.push_back(100);
      pushExpected(0, 100, 0);
      applyStimulus(4'b0001, 1'b1);
      @(negedge clk);
      checkOutput("select_busy", int'(busy), 1);
      checkOutput("select_step_set", int'(step_set), 0);
      @(negedge clk);
      checkOutput("charge_step_set", int'(step_set), 1);
      applyStimulus(4'b0001, 1'b0);
      waitIdle("first_meas_idle", 3000);

      // Asynchronous reset in the middle of a ch1 charge, then restart from ch0
      delay_q.push_back(-1);
      applyStimulus(4'b0010, 1'b1);
      waitStep("ch1_charge_start", 20);
      checkOutput("ch1_step_set", int'(step_set), 2);
      repeat (20) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_rst_step_set", int'(step_set), 0);
      checkOutput("async_rst_busy", int'(busy), 0);
      applyStimulus(4'b0011, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      delay_q.push_back(100);
      pushExpected(0, 100, 0);
      applyStimulus(4'b0011, 1'b1);
      waitStep("restart_charge", 20);
      checkOutput("restart_at_ch0", int'(step_set), 1);
      applyStimulus(4'b0011, 1'b0);
      waitIdle("restart_idle", 3000);

      // Round robin over channels 1 and 3
      for (int i = 0; i < 4; i++) begin
         delay_q.push_back(100);
         pushExpected((i % 2 == 0) ? 1 : 3, 100, 0);
      end
      base = meas_seen;
      applyStimulus(4'b1010, 1'b1);
      waitMeas("rr_four_meas", base + 4, 6000);
      applyStimulus(4'b1010, 1'b0);
      waitIdle("rr_idle", 3000);

      // ch0 never charges: timeout report, full discharge, then ch1 enabled mid-measurement
      delay_q.push_back(-1);
      pushExpected(0, 1000, 1);
      delay_q.push_back(100);
      pushExpected(1, 100, 0);
      base = meas_seen;
      applyStimulus(4'b0001, 1'b1);
      waitMeas("timeout_meas", base + 1, 1500);
      applyStimulus(4'b0011, 1'b1);
      waitStep("after_timeout_next", 1500);
      gap = cycle - last_meas_cycle;
      checkOutput("timeout_discharge_gap", int'(gap >= 1000 && gap <= 1010), 1);
      checkOutput("after_timeout_ch1", int'(step_set), 2);
      applyStimulus(4'b0011, 1'b0);
      waitIdle("timeout_idle", 3000);

      // Stray calc_done while idle must not start anything
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("stray_done_busy", int'(busy), 0);
      checkOutput("stray_done_step_set", int'(step_set), 0);

      // Slow calculator: discharge must wait for calc_done; run dropped during ch2 charge
      calc_delay = 5000;
      delay_q.push_back(50);
      pushExpected(2, 50, 0);
      base = meas_seen;
      applyStimulus(4'b0100, 1'b1);
      waitStep("ch2_charge_start", 20);
      checkOutput("ch2_step_set", int'(step_set), 4);
      applyStimulus(4'b0100, 1'b0);
      waitMeas("ch2_meas", base + 1, 200);
      repeat (3000) @(negedge clk);
      checkOutput("busy_waits_calc_done", int'(busy), 1);
      waitIdle("ch2_idle", 4000);
      idle_cycle = cycle;
      checkOutput("idle_after_calc_done", int'(idle_cycle > done_cycle && done_cycle > 0), 1);
      calc_delay = 3;

      // Shorted sensor: step_input already high on charge entry
      delay_q.push_back(0);
      pushExpected(3, 0, 0);
      applyStimulus(4'b1000, 1'b1);
      waitStep("short_charge_start", 20);
      applyStimulus(4'b1000, 1'b0);
      waitIdle("short_idle", 3000);

`ifdef RC_SCHED_AVG_EN
      // Four samples averaged into a single report
      delay_q.push_back(100);
      delay_q.push_back(102);
      delay_q.push_back(98);
      delay_q.push_back(104);
      pushExpected(0, 101, 0);
      applyStimulus(4'b0001, 1'b1);
      waitStep("avg_charge_start", 20);
      applyStimulus(4'b0001, 1'b0);
      waitIdle("avg_idle", 8000);
`endif

      repeat (5) @(negedge clk);
      checkOutput("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
